// File: rtl/ring_arbiter_pkg.sv
// Shared state encoding and pointer reset position for the ring arbiter.
package ring_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } arb_state_t;

   // Requester index the priority pointer points at after reset.
   localparam int unsigned PTR_RST_BIT = 0;

endpackage

// File: rtl/ring_arbiter_if.sv
// Requester-side bundle of the ring arbiter: request/enable in, grant status back.
interface ring_arbiter_if #(
   parameter int N    = 4,
   parameter int IDXW = 2
);
   logic            en;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic [IDXW-1:0] owner;
   logic            busy;
   logic            timeout;

   modport master (output en, req, input grant, owner, busy, timeout);
   modport slave  (input en, req, output grant, owner, busy, timeout);
endinterface

// File: rtl/ring_arbiter_rr_pointer.sv
// One-hot priority pointer; on load it moves to the bit just above the winner, wrapping.
module ring_arbiter_rr_pointer
   import ring_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] winner,
   output logic [N-1:0] ptr
);
   logic [N-1:0] nxt;

   assign nxt = {winner[N-2:0], winner[N-1]};

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= N'(1) << PTR_RST_BIT;
      else if (load)
         ptr <= nxt;
   end
endmodule

// File: rtl/ring_arbiter.sv
// Round-robin arbiter: registered one-hot grant 1 edge after req in IDLE, tenure capped at HOLD_MAX.
// Holding en low freezes an active tenure; every handover passes through GAP and IDLE.
module ring_arbiter
   import ring_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int IDXW     = 2,
   parameter int HOLD_MAX = 8,
   parameter int HOLD_W   = 3
) (
   input  logic           clk,
   input  logic           reset,
   ring_arbiter_if.slave  arb
);
   arb_state_t      state;
   logic [HOLD_W-1:0] cnt;
   logic [N-1:0]    ptr;
   logic [N-1:0]    win_oh;
   logic [IDXW-1:0] pidx;
   logic [IDXW-1:0] lo_idx;
   logic [IDXW-1:0] hi_idx;
   logic [IDXW-1:0] win_idx;
   logic            hi_any;
   logic            win_vld;
   logic            load;

   logic [N-1:0]    grant_q;
   logic [IDXW-1:0] owner_q;
   logic            busy_q;
   logic            timeout_q;

   // Two-pass scan: lowest request at or above the pointer wins, else lowest overall.
   always_comb begin
      pidx   = '0;
      lo_idx = '0;
      hi_idx = '0;
      hi_any = 1'b0;
      for (int i = 0; i < N; i++)
         if (ptr[i]) pidx = IDXW'(i);
      for (int i = N - 1; i >= 0; i--) begin
         if (arb.req[i])
            lo_idx = IDXW'(i);
         if (arb.req[i] && (i >= int'(pidx))) begin
            hi_idx = IDXW'(i);
            hi_any = 1'b1;
         end
      end
   end

   assign win_vld = |arb.req;
   assign win_idx = hi_any ? hi_idx : lo_idx;
   assign win_oh  = N'(1) << win_idx;
   assign load    = (state == ARB_IDLE) && arb.en && win_vld;

   ring_arbiter_rr_pointer #(.N(N)) u_ptr (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .winner (win_oh),
      .ptr    (ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         cnt       <= '0;
         grant_q   <= '0;
         owner_q   <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (arb.en && win_vld) begin
                  state   <= ARB_GRANT;
                  grant_q <= win_oh;
                  owner_q <= win_idx;
                  busy_q  <= 1'b1;
                  cnt     <= '0;
               end
            end
            ARB_GRANT: begin
               if (arb.en) begin
                  if (!arb.req[owner_q] || (cnt == HOLD_W'(HOLD_MAX - 1))) begin
                     state     <= ARB_GAP;
                     grant_q   <= '0;
                     owner_q   <= '0;
                     busy_q    <= 1'b0;
                     timeout_q <= arb.req[owner_q];
                  end else begin
                     cnt <= cnt + HOLD_W'(1);
                  end
               end
            end
            ARB_GAP:  state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
      end
   end

   assign arb.grant   = grant_q;
   assign arb.owner   = owner_q;
   assign arb.busy    = busy_q;
   assign arb.timeout = timeout_q;
endmodule

// File: tb/tb_ring_arbiter.sv
// Scenario bench for ring_arbiter: per-cycle expected outputs are queued alongside the stimulus.
module tb_ring_arbiter;
   import ring_arbiter_pkg::*;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic [3:0] req;
   } stim_t;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] o;
      logic       b;
      logic       t;
   } exp_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   stim_t sq[$];
   exp_t  eq[$];

   ring_arbiter_if #(.N(4), .IDXW(2)) ifc ();

   ring_arbiter #(.N(4), .IDXW(2), .HOLD_MAX(8), .HOLD_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stim(input logic r, input logic e, input logic [3:0] rq, input int n);
      stim_t s;
      s = '{rst: r, en: e, req: rq};
      repeat (n) sq.push_back(s);
   endtask

   task automatic exp_grant(input logic [3:0] g, input logic [1:0] o, input int n);
      exp_t x;
      x = '{g: g, o: o, b: 1'b1, t: 1'b0};
      repeat (n) eq.push_back(x);
   endtask

   task automatic exp_none(input logic t, input int n);
      exp_t x;
      x = '{g: 4'b0000, o: 2'd0, b: 1'b0, t: t};
      repeat (n) eq.push_back(x);
   endtask

   task automatic test_reset();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      stim(1'b1, 1'b1, 4'b1111, 2); exp_none(1'b0, 2);
      stim(1'b0, 1'b1, 4'b1111, 1); exp_grant(4'b0001, 2'd0, 1);
      stim(1'b1, 1'b0, 4'b0000, 1); exp_none(1'b0, 1);
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL reset cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL reset cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   task automatic test_fairness();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      logic [3:0] oh;
      stim(1'b0, 1'b1, 4'b1111, 50);
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % 4);
         exp_grant(oh, 2'(k % 4), 8);
         exp_none(1'b1, 1);
         exp_none(1'b0, 1);
      end
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL fairness cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL fairness cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   task automatic test_early_release();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      stim(1'b0, 1'b1, 4'b0100, 3); exp_grant(4'b0100, 2'd2, 3);
      stim(1'b0, 1'b1, 4'b0000, 2); exp_none(1'b0, 2);
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL early_release cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL early_release cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   task automatic test_wrap();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      // Pointer sits at bit 3 here, so requester 0 must win via wrap-around.
      stim(1'b0, 1'b1, 4'b0011, 3); exp_grant(4'b0001, 2'd0, 3);
      stim(1'b0, 1'b1, 4'b0010, 4); exp_none(1'b0, 2); exp_grant(4'b0010, 2'd1, 2);
      stim(1'b0, 1'b1, 4'b0000, 2); exp_none(1'b0, 2);
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL wrap cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL wrap cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   task automatic test_enable();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      stim(1'b0, 1'b0, 4'b0010, 3);  exp_none(1'b0, 3);
      stim(1'b0, 1'b1, 4'b0010, 3);  exp_grant(4'b0010, 2'd1, 3);
      stim(1'b0, 1'b0, 4'b0010, 10); exp_grant(4'b0010, 2'd1, 10);
      // Counter resumes at 2: five more increments, then the cut.
      stim(1'b0, 1'b1, 4'b0010, 5);  exp_grant(4'b0010, 2'd1, 5);
      stim(1'b0, 1'b1, 4'b0010, 1);  exp_none(1'b1, 1);
      stim(1'b0, 1'b0, 4'b0000, 1);  exp_none(1'b0, 1);
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL enable cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL enable cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      stim_t s;
      exp_t  x;
      exp_t  got;
      int    cyc;
      stim(1'b0, 1'b1, 4'b1000, 2); exp_grant(4'b1000, 2'd3, 2);
      stim(1'b1, 1'b1, 4'b1001, 1); exp_none(1'b0, 1);
      stim(1'b0, 1'b1, 4'b1001, 1); exp_grant(4'b0001, 2'd0, 1);
      stim(1'b0, 1'b1, 4'b0000, 2); exp_none(1'b0, 2);
      cyc = 0;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         reset = s.rst; ifc.en = s.en; ifc.req = s.req;
         @(posedge clk); #1;
         cyc++;
         compared++;
         if (eq.size() == 0) begin
            mismatched++;
            $display("FAIL reset_mid_grant cyc %0d: no expected entry queued", cyc);
         end else begin
            x   = eq.pop_front();
            got = '{g: ifc.grant, o: ifc.owner, b: ifc.busy, t: ifc.timeout};
            if (got !== x) begin
               mismatched++;
               $display("FAIL reset_mid_grant cyc %0d: got g=%b o=%0d b=%b t=%b, want g=%b o=%0d b=%b t=%b",
                        cyc, got.g, got.o, got.b, got.t, x.g, x.o, x.b, x.t);
            end
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      ifc.en     = 1'b0;
      ifc.req    = 4'b0000;
      test_reset();
      test_fairness();
      test_early_release();
      test_wrap();
      test_enable();
      test_reset_mid_grant();
      if (eq.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL leftover: %0d expected entries never consumed, want 0", eq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
